// File: rtl/vga_timing_gen.sv
// Parametrised VGA/CEA raster timing generator with registered sync/blank/position outputs.
// Optional frame counter enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned FRAME_W  = 8,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned X_W     = $clog2(H_TOTAL),
  localparam int unsigned Y_W     = $clog2(V_TOTAL)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pix_stb,
  output logic               o_hs,
  output logic               o_vs,
  output logic               o_de,
  output logic               o_hblank,
  output logic               o_vblank,
  output logic [X_W-1:0]     o_x,
  output logic [Y_W-1:0]     o_y,
  output logic               o_sol,
  output logic               o_sof,
  output logic [FRAME_W-1:0] o_frame_cnt
);

  localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END = V_ACTIVE + V_FP + V_SYNC;

  logic [X_W-1:0] h_cnt;
  logic [Y_W-1:0] v_cnt;
  logic           h_last;
  logic           v_last;
  logic           h_act;
  logic           v_act;
  logic           h_sync;
  logic           v_sync;
  logic           h_zero;
  logic           origin;

  // Decode of the current (pre-advance) raster position.
  always_comb begin
    h_last = (h_cnt == X_W'(H_TOTAL - 1));
    v_last = (v_cnt == Y_W'(V_TOTAL - 1));
    h_act  = (h_cnt <  X_W'(H_ACTIVE));
    v_act  = (v_cnt <  Y_W'(V_ACTIVE));
    h_sync = (h_cnt >= X_W'(H_SYNC_BEG)) && (h_cnt < X_W'(H_SYNC_END));
    v_sync = (v_cnt >= Y_W'(V_SYNC_BEG)) && (v_cnt < Y_W'(V_SYNC_END));
    h_zero = (h_cnt == '0);
    origin = h_zero && (v_cnt == '0);
  end

  // Raster counters: v advances only when h wraps.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (i_pix_stb) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + Y_W'(1);
      end else begin
        h_cnt <= h_cnt + X_W'(1);
      end
    end
  end

  // Output register: loads the decode on a strobe, holds otherwise; pulses self-clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_x      <= '0;
      o_y      <= '0;
      o_de     <= 1'b0;
      o_hblank <= 1'b1;
      o_vblank <= 1'b1;
      o_hs     <= ~HS_POL;
      o_vs     <= ~VS_POL;
      o_sol    <= 1'b0;
      o_sof    <= 1'b0;
    end else if (i_pix_stb) begin
      o_x      <= h_cnt;
      o_y      <= v_cnt;
      o_de     <= h_act && v_act;
      o_hblank <= ~h_act;
      o_vblank <= ~v_act;
      o_hs     <= h_sync ? HS_POL : ~HS_POL;
      o_vs     <= v_sync ? VS_POL : ~VS_POL;
      o_sol    <= h_zero;
      o_sof    <= origin;
    end else begin
      o_sol    <= 1'b0;
      o_sof    <= 1'b0;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Counts frames started since reset; first frame reads 1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_frame_cnt <= '0;
    end else if (i_pix_stb && origin) begin
      o_frame_cnt <= o_frame_cnt + FRAME_W'(1);
    end
  end
`else
  assign o_frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: default 640x480 instance plus a tiny-mode
// instance, both compared every cycle against a strobe-count arithmetic model.
module tb_vga_timing_gen;

  // Small mode: 12 pixels/line, 9 lines/frame, active-high hsync.
  localparam int SH_A = 5, SH_F = 2, SH_S = 3, SH_B = 2;
  localparam int SV_A = 4, SV_F = 1, SV_S = 2, SV_B = 2;

  typedef struct {
    longint x, y, fc;
    bit hs, vs, de, hb, vb, sol, sof;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stb = 1'b0;
  always #5 clk = ~clk;

  logic       hs_a, vs_a, de_a, hb_a, vb_a, sol_a, sof_a;
  logic [9:0] x_a, y_a;
  logic [7:0] fc_a;
  logic       hs_b, vs_b, de_b, hb_b, vb_b, sol_b, sof_b;
  logic [3:0] x_b, y_b;
  logic [1:0] fc_b;

  vga_timing_gen dut_a (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb),
    .o_hs(hs_a), .o_vs(vs_a), .o_de(de_a), .o_hblank(hb_a), .o_vblank(vb_a),
    .o_x(x_a), .o_y(y_a), .o_sol(sol_a), .o_sof(sof_a), .o_frame_cnt(fc_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
    .HS_POL(1'b1), .VS_POL(1'b0), .FRAME_W(2)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb),
    .o_hs(hs_b), .o_vs(vs_b), .o_de(de_b), .o_hblank(hb_b), .o_vblank(vb_b),
    .o_x(x_b), .o_y(y_b), .o_sol(sol_b), .o_sof(sof_b), .o_frame_cnt(fc_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected outputs from the number of strobes k accepted since reset.
  function automatic exp_t model(input longint k, input bit pul,
                                 input int ha, input int hf, input int hsw, input int hbp,
                                 input int va, input int vf, input int vsw, input int vbp,
                                 input bit hp, input bit vp, input int fw);
    exp_t e;
    longint ht, vt, p;
    ht = longint'(ha + hf + hsw + hbp);
    vt = longint'(va + vf + vsw + vbp);
    if (k == 0) begin
      e.x = 0; e.y = 0; e.fc = 0;
      e.de = 1'b0; e.hb = 1'b1; e.vb = 1'b1;
      e.hs = ~hp; e.vs = ~vp; e.sol = 1'b0; e.sof = 1'b0;
      return e;
    end
    p   = k - 1;
    e.x = p % ht;
    e.y = (p / ht) % vt;
    e.hb = (e.x >= ha);
    e.vb = (e.y >= va);
    e.de = !e.hb && !e.vb;
    e.hs = (e.x >= ha + hf && e.x < ha + hf + hsw) ? hp : ~hp;
    e.vs = (e.y >= va + vf && e.y < va + vf + vsw) ? vp : ~vp;
    e.sol = pul && (e.x == 0);
    e.sof = e.sol && (e.y == 0);
`ifdef VGA_FRAME_CNT_EN
    e.fc = (p / (ht * vt) + 1) % (longint'(1) << fw);
`else
    e.fc = 0;
`endif
    return e;
  endfunction

  longint k = 0;
  bit     pul = 1'b0;
  bit     armed = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      k <= 0; pul <= 1'b0; armed <= 1'b1;
    end else if (stb) begin
      k <= k + 1; pul <= 1'b1;
    end else begin
      pul <= 1'b0;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (armed) begin
      exp_t ea, eb;
      ea = model(k, pul, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 8);
      eb = model(k, pul, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 1'b1, 1'b0, 2);
      chk("a_x", longint'(x_a), ea.x);       chk("a_y", longint'(y_a), ea.y);
      chk("a_hs", longint'(hs_a), longint'(ea.hs)); chk("a_vs", longint'(vs_a), longint'(ea.vs));
      chk("a_de", longint'(de_a), longint'(ea.de)); chk("a_hblank", longint'(hb_a), longint'(ea.hb));
      chk("a_vblank", longint'(vb_a), longint'(ea.vb)); chk("a_sol", longint'(sol_a), longint'(ea.sol));
      chk("a_sof", longint'(sof_a), longint'(ea.sof)); chk("a_fc", longint'(fc_a), ea.fc);
      chk("b_x", longint'(x_b), eb.x);       chk("b_y", longint'(y_b), eb.y);
      chk("b_hs", longint'(hs_b), longint'(eb.hs)); chk("b_vs", longint'(vs_b), longint'(eb.vs));
      chk("b_de", longint'(de_b), longint'(eb.de)); chk("b_hblank", longint'(hb_b), longint'(eb.hb));
      chk("b_vblank", longint'(vb_b), longint'(eb.vb)); chk("b_sol", longint'(sol_b), longint'(eb.sol));
      chk("b_sof", longint'(sof_b), longint'(eb.sof)); chk("b_fc", longint'(fc_b), eb.fc);
    end
  end

  // Apply inputs away from the edge, consume one edge, return 1 time unit after it.
  task automatic cyc(input bit s, input bit r);
    stb = s;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  int  hs_cnt, hs_min, hs_max, de_fall, sol_gap, sol_per;
  bit  prev_de;
  int  strobes, last_sof, vs_min, vs_max, hsb_min, hsb_max, ymax, nfr;
  bit  wrap_seen;
  int  prev_y, prev_fc;
  bit  found, s, r;
  int  tries;

  initial begin
    // Reset and first strobe
    repeat (3) cyc(1'b0, 1'b1);
    chk("rst_x", longint'(x_a), 0);      chk("rst_de", longint'(de_a), 0);
    chk("rst_hblank", longint'(hb_a), 1); chk("rst_hs_a", longint'(hs_a), 1);
    chk("rst_hs_b", longint'(hs_b), 0);  chk("rst_fc", longint'(fc_a), 0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    chk("first_x", longint'(x_a), 0);    chk("first_y", longint'(y_a), 0);
    chk("first_de", longint'(de_a), 1);  chk("first_hblank", longint'(hb_a), 0);
    chk("first_sof", longint'(sof_a), 1); chk("first_sol", longint'(sol_a), 1);
`ifdef VGA_FRAME_CNT_EN
    chk("first_fc", longint'(fc_a), 1);
`else
    chk("first_fc", longint'(fc_a), 0);
`endif
    cyc(1'b0, 1'b0);
    chk("first_sof_clr", longint'(sof_a), 0); chk("first_sol_clr", longint'(sol_a), 0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);

    // One full line at a quarter-rate strobe
    hs_cnt = 0; hs_min = 99999; hs_max = -1; de_fall = -1; prev_de = 1'b1;
    sol_gap = 0; sol_per = -1;
    for (int i = 1; i <= 800; i++) begin
      cyc(1'b1, 1'b0);
      sol_gap++;
      if (sol_a) begin sol_per = sol_gap; sol_gap = 0; end
      if (!hs_a) begin
        hs_cnt++;
        if (int'(x_a) < hs_min) hs_min = int'(x_a);
        if (int'(x_a) > hs_max) hs_max = int'(x_a);
      end
      if (prev_de && !de_a && de_fall < 0) de_fall = int'(x_a);
      prev_de = de_a;
      repeat (3) cyc(1'b0, 1'b0);
    end
    chk("hs_low_count", hs_cnt, 96); chk("hs_first_x", hs_min, 656);
    chk("hs_last_x", hs_max, 751);   chk("de_fall_x", de_fall, 640);
    chk("sol_period", sol_per, 800);

    // Random-rate strobes across many small-mode frames
    strobes = 0; last_sof = -1; vs_min = 99; vs_max = -1; hsb_min = 99; hsb_max = -1;
    ymax = 0; wrap_seen = 1'b0; prev_y = int'(y_b); nfr = 0; prev_fc = 0;
    for (int i = 0; i < 3000; i++) begin
      s = 1'($urandom_range(0, 1));
      cyc(s, 1'b0);
      if (s) strobes++;
      if (sof_b) begin
        if (last_sof >= 0) chk("b_sof_period", strobes - last_sof, 108);
        last_sof = strobes;
`ifdef VGA_FRAME_CNT_EN
        if (nfr > 0) chk("b_fc_step", longint'(fc_b), (prev_fc + 1) % 4);
`else
        chk("b_fc_zero", longint'(fc_b), 0);
`endif
        prev_fc = int'(fc_b);
        nfr++;
      end
      if (!vs_b) begin
        if (int'(y_b) < vs_min) vs_min = int'(y_b);
        if (int'(y_b) > vs_max) vs_max = int'(y_b);
      end
      if (hs_b) begin
        if (int'(x_b) < hsb_min) hsb_min = int'(x_b);
        if (int'(x_b) > hsb_max) hsb_max = int'(x_b);
      end
      if (int'(y_b) > ymax) ymax = int'(y_b);
      if (prev_y == 8 && y_b == 4'd0) wrap_seen = 1'b1;
      prev_y = int'(y_b);
    end
    chk("b_vs_first_y", vs_min, 5);  chk("b_vs_last_y", vs_max, 6);
    chk("b_hs_first_x", hsb_min, 7); chk("b_hs_last_x", hsb_max, 9);
    chk("b_y_max", ymax, 8);         chk("b_y_wrap", longint'(wrap_seen), 1);

    // Strobe pause at x=123
    found = 1'b0;
    for (tries = 0; tries < 900 && !found; tries++) begin
      cyc(1'b1, 1'b0);
      if (x_a == 10'd123) found = 1'b1;
    end
    chk("reach_x123", longint'(found), 1);
    if (found) begin
      for (int i = 0; i < 100; i++) begin
        cyc(1'b0, 1'b0);
        chk("hold_x", longint'(x_a), 123); chk("hold_hblank", longint'(hb_a), 0);
        chk("hold_hs", longint'(hs_a), 1); chk("hold_sol", longint'(sol_a), 0);
      end
      cyc(1'b1, 1'b0);
      chk("resume_x", longint'(x_a), 124);
    end

    // Reset with strobe asserted mid-frame
    found = 1'b0;
    for (tries = 0; tries < 900 && !found; tries++) begin
      cyc(1'b1, 1'b0);
      if (x_a == 10'd300) found = 1'b1;
    end
    chk("reach_x300", longint'(found), 1);
    cyc(1'b1, 1'b1);
    chk("mrst_x", longint'(x_a), 0);      chk("mrst_y", longint'(y_a), 0);
    chk("mrst_de", longint'(de_a), 0);    chk("mrst_hblank", longint'(hb_a), 1);
    chk("mrst_vblank", longint'(vb_a), 1); chk("mrst_hs", longint'(hs_a), 1);
    chk("mrst_vs", longint'(vs_a), 1);    chk("mrst_sof", longint'(sof_a), 0);
    chk("mrst_fc", longint'(fc_a), 0);    chk("mrst_hs_b", longint'(hs_b), 0);
    cyc(1'b1, 1'b0);
    chk("post_x", longint'(x_a), 0);      chk("post_y", longint'(y_a), 0);
    chk("post_sof", longint'(sof_a), 1);  chk("post_sof_b", longint'(sof_b), 1);
`ifdef VGA_FRAME_CNT_EN
    chk("post_fc_b", longint'(fc_b), 1);
`else
    chk("post_fc_b", longint'(fc_b), 0);
`endif

    // Random strobes with occasional resets
    for (int i = 0; i < 3000; i++) begin
      s = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 399) == 0);
      cyc(s, r);
    end
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
